lfsr_rng: RTL
=============

// Module: lfsr_rng
// PURPOSE
//  Parametrised XNOR Fibonacci LFSR random source with a stream output.
//  Produces a WIDTH-bit random word and a Bernoulli bit (word >= runtime threshold) under valid/ready.
//  Supports runtime reseed and an optional multi-bit leap per step.
//  Feeds game/event logic that needs random words or weighted coin flips.
// PARAMETERS
//  WIDTH = 8      LFSR/word width, 4..32
//  TAPS  = 8'hB8  feedback tap mask, WIDTH bits; bit i set => q[i] in feedback
//  SEED  = 0      reset seed; must not be all-ones
//  STEP  = 4      bits advanced per step when LFSR_LEAP_EN is defined, 1..WIDTH
// PORTS
//  clk_i     in   1      clock, rising edge
//  rst_i     in   1      asynchronous reset, active-high
//  en_i      in   1      permit generation of a new word
//  load_i    in   1      reseed strobe
//  seed_i    in   WIDTH  reseed value
//  prob_i    in   WIDTH  Bernoulli threshold
//  word_o    out  WIDTH  registered random word
//  bit_o     out  1      registered (word >= prob_i at capture)
//  valid_o   out  1      word_o/bit_o hold an unconsumed sample
//  ready_i   in   1      consumer accepts sample when valid_o & ready_i
//  count_o   out  16     number of samples accepted, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: lfsr_q=SEED; word_o=0; bit_o=0; valid_o=0; count_o=0; FSM=EMPTY.
//  Feedback: fb = ~^(lfsr_q & TAPS); shift: lfsr_q <= {lfsr_q[WIDTH-2:0], fb}.
//  All-ones is the lock-up state and is never entered from a legal seed.
//  FSM EMPTY (valid_o=0):
//   - en_i=1: capture word_o<=lfsr_q, bit_o<=(lfsr_q>=prob_i), advance lfsr_q, go FULL.
//   - en_i=0: hold.
//  FSM FULL (valid_o=1):
//   - ready_i=1 & en_i=1: count_o++; capture next word and advance in the same cycle (1 sample/clk); stay FULL.
//   - ready_i=1 & en_i=0: count_o++; go EMPTY.
//   - ready_i=0: hold word_o, bit_o and lfsr_q. No advance, no drop.
//  load_i (priority over all of the above, either state):
//   - lfsr_q <= (seed_i == all-ones) ? SEED : seed_i; valid_o<=0; go EMPTY.
//   - If valid_o & ready_i in the same cycle, count_o still increments (sample delivered); no capture.
//  Latency: first valid_o 1 clk after en_i in EMPTY. Comparison is unsigned.
//  prob_i=0 => bit_o always 1. prob_i=all-ones => bit_o=1 only for word all-ones, which never occurs.
//  Mid-operation reset: async clear to reset values regardless of handshake state.
// CONFIGURATION
//  LFSR_LEAP_EN defined: each advance applies the shift/feedback STEP times combinationally.
//   Successive words are decorrelated by STEP bits.
//  Undefined: one shift per advance; STEP is ignored.
//  Handshake, reseed and count behaviour are identical in both builds.
// STRUCTURE
//  lfsr_pkg: default TAPS constants per width (maximal-length masks 4..32); count width constant CNT_W=16.
//  Sub-module lfsr_step: combinational next-state, params WIDTH/TAPS/NSTEP.
//   Instantiated with NSTEP=STEP or 1 depending on LFSR_LEAP_EN.
//  Top holds FSM, output register, counter.
// TESTING
//  Sequence: WIDTH=8, TAPS=8'hB8, SEED=0, no LEAP; en_i=1, ready_i=1 -> word_o sequence 00,01,03,07,0F,1E; count_o increments each clk.
//  Backpressure: ready_i=0 for 5 clk while FULL -> word_o, lfsr_q and count_o frozen; release gives next word with no skip.
//  Threshold: prob_i=8'h80 -> bit_o==(word_o>=8'h80) for 255 samples; prob_i=0 -> bit_o=1 throughout.
//  Reseed: load_i with seed_i=8'h5A while FULL -> valid_o=0 next clk; next captured word=8'h5A. seed_i=8'hFF -> word=SEED.
//  Period/lock: 255 accepted samples from SEED=0 return word_o to 00; all-ones never appears.
//  Reset mid-stream: assert rst_i while FULL, ready_i=0 -> all outputs at reset values immediately. LEAP build, STEP=4: second word is 8'h0F.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR random source: default maximal-length
// tap masks per width, sample counter width and stream FSM states.
package lfsr_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Maximal-length XNOR tap masks, bit i set => q[i] feeds back.
    function automatic logic [31:0] lfsr_taps(input int w);
        logic [31:0] t;
        case (w)
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            17:      t = 32'h0001_2000;
            18:      t = 32'h0002_0400;
            19:      t = 32'h0004_0023;
            20:      t = 32'h0009_0000;
            21:      t = 32'h0014_0000;
            22:      t = 32'h0030_0000;
            23:      t = 32'h0042_0000;
            24:      t = 32'h00E1_0000;
            25:      t = 32'h0120_0000;
            26:      t = 32'h0200_0023;
            27:      t = 32'h0400_0013;
            28:      t = 32'h0900_0000;
            29:      t = 32'h1400_0000;
            30:      t = 32'h2000_0029;
            31:      t = 32'h4800_0000;
            default: t = 32'h8020_0003;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational XNOR Fibonacci next-state, NSTEP shifts per call.
// Ports: cur (present state), nxt (state after NSTEP shifts).
module lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               NSTEP = 1
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = cur;
        for (int k = 0; k < NSTEP; k++) begin
            s = {s[WIDTH-2:0], ~^(s & TAPS)};
        end
    end

    assign nxt = s;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random word + Bernoulli bit source on a valid/ready stream.
// Ports: clk_i, rst_i (async, active-high), en_i, load_i, seed_i, prob_i,
//   word_o, bit_o, valid_o, ready_i, count_o.
// Macro LFSR_LEAP_EN: advance STEP shifts per sample instead of one.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter int               STEP  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic [WIDTH-1:0] prob_i,
    output logic [WIDTH-1:0] word_o,
    output logic             bit_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o
);

`ifdef LFSR_LEAP_EN
    localparam int NSTEP = STEP;
`else
    // STEP only matters in the leap build.
    localparam int NSTEP = (STEP > 0) ? 1 : 1;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] word_q;
    logic             bit_q;
    logic [CNT_W-1:0] count_q;
    logic             take;

    lfsr_step #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .NSTEP(NSTEP)
    ) u_step (
        .cur(lfsr_q),
        .nxt(lfsr_nxt)
    );

    assign take = (state_q == FULL) && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            lfsr_q  <= SEED;
            word_q  <= '0;
            bit_q   <= 1'b0;
            count_q <= '0;
        end else begin
            // A sample seen by the consumer counts even when a reseed
            // happens in the same cycle.
            if (take) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (load_i) begin
                // All-ones would lock the XNOR register up.
                lfsr_q  <= (&seed_i) ? SEED : seed_i;
                state_q <= EMPTY;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (en_i) begin
                            word_q  <= lfsr_q;
                            bit_q   <= (lfsr_q >= prob_i);
                            lfsr_q  <= lfsr_nxt;
                            state_q <= FULL;
                        end
                    end
                    FULL: begin
                        if (ready_i) begin
                            if (en_i) begin
                                word_q <= lfsr_q;
                                bit_q  <= (lfsr_q >= prob_i);
                                lfsr_q <= lfsr_nxt;
                            end else begin
                                state_q <= EMPTY;
                            end
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign word_o  = word_q;
    assign bit_o   = bit_q;
    assign valid_o = (state_q == FULL);
    assign count_o = count_q;

endmodule
